// File: rtl/hs_mem_spram_ctrl.sv
// hs_mem_spram_ctrl
// Request-side controller for the single-port asynchronous-read RAM
// (hs_mem_spram_asyncrd). Accepts read/write requests on a valid/ready channel,
// drives the RAM port, and returns read data through a registered valid/ready
// response channel.
//
// Optional feature, macro HS_MEM_SPRAM_CTRL_INIT_EN:
//   defined   - after reset an INIT sweep zero-fills addresses 0..DATA_DEPTH-1
//               before requests are accepted (the RAM itself has no reset).
//   undefined - RUN is entered straight out of reset and init_done is tied high.
module hs_mem_spram_ctrl #(
   parameter type DATA_TYPE  = logic [7:0],
   parameter int  DATA_DEPTH = 16,
   localparam int ADDR_WIDTH = $clog2(DATA_DEPTH)
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic                  req_valid,
   output logic                  req_ready,
   input  logic                  req_we,
   input  logic [ADDR_WIDTH-1:0] req_addr,
   input  DATA_TYPE              req_wdata,
   output logic                  rsp_valid,
   input  logic                  rsp_ready,
   output DATA_TYPE              rsp_rdata,
   output logic                  init_done,
   output logic [ADDR_WIDTH-1:0] mem_addr,
   output DATA_TYPE              mem_wdata,
   output logic                  mem_wen,
   input  DATA_TYPE              mem_rdata
);

   logic                  in_run;       // controller accepts requests
   logic                  init_active;  // zero-fill sweep owns the RAM port
   logic [ADDR_WIDTH-1:0] sweep_addr;   // address written by the sweep
   logic                  rd_ok;        // response register can take new data
   logic                  wr_acc;       // write accepted this cycle
   logic                  rd_acc;       // read accepted this cycle

`ifdef HS_MEM_SPRAM_CTRL_INIT_EN
   localparam logic [0:0]            ST_INIT   = 1'b0;
   localparam logic [0:0]            ST_RUN    = 1'b1;
   localparam logic [ADDR_WIDTH-1:0] LAST_ADDR = ADDR_WIDTH'(DATA_DEPTH - 1);

   logic [0:0]            state;
   logic [ADDR_WIDTH-1:0] init_cnt;

   // Sweep counter: walk 0..DATA_DEPTH-1 once, then hand over to RUN.
   always_ff @(posedge clk) begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // updates from the values present before the edge.
      if (rst) begin
         state    <= ST_INIT;
         init_cnt <= '0;
      end else if (state == ST_INIT) begin
         init_cnt <= init_cnt + ADDR_WIDTH'(1);
         if (init_cnt == LAST_ADDR) begin
            state <= ST_RUN;
         end
      end
   end

   assign in_run      = (state == ST_RUN);
   assign init_active = (state == ST_INIT);
   assign sweep_addr  = init_cnt;
`else
   assign in_run      = 1'b1;
   assign init_active = 1'b0;
   assign sweep_addr  = '0;
`endif

   assign init_done = in_run;

   // Request handshake and RAM port steering (writes pass straight through).
   always_comb begin
      // NOTE: every output gets a default first so no latch is inferred.
      rd_ok     = !rsp_valid || rsp_ready;
      req_ready = 1'b0;
      wr_acc    = 1'b0;
      rd_acc    = 1'b0;
      mem_addr  = req_addr;
      mem_wdata = req_wdata;
      mem_wen   = 1'b0;
      if (in_run) begin
         // Writes never wait on the response register; reads need a free slot.
         req_ready = req_we ? 1'b1 : rd_ok;
         wr_acc    = req_valid && req_we;
         rd_acc    = req_valid && !req_we && rd_ok;
      end
      if (init_active) begin
         // Sweep writes are not gated by rst so a reset simply restarts them.
         mem_wen   = 1'b1;
         mem_addr  = sweep_addr;
         mem_wdata = '0;
      end else begin
         // A write offered while rst is high must not reach the RAM.
         mem_wen = wr_acc && !rst;
      end
   end

   // Response register: capture async RAM data on read accept, hold under stall.
   always_ff @(posedge clk) begin
      if (rst) begin
         rsp_valid <= 1'b0;
         rsp_rdata <= '0;
      end else if (rd_acc) begin
         rsp_valid <= 1'b1;
         rsp_rdata <= mem_rdata;
      end else if (rsp_ready) begin
         rsp_valid <= 1'b0;
      end
   end

endmodule
